// File: rtl/blk_scan_engine_if.sv
// Bus bundle for the block-scan controller: start/abort handshake, memory read
// port, per-point core inputs and the per-block result outputs.
interface blk_scan_engine_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DIST_WIDTH = 14,
    parameter int PEAK_NUM   = 4,
    parameter int REF_MAX    = 3,
    parameter int REF_CNT_W  = 2,
    parameter int CNT_WIDTH  = 8
);
    logic                           start;
    logic [1:0]                     mode;
    logic                           abort;
    logic                           busy;
    logic                           done;
    logic                           rd_en;
    logic [ADDR_WIDTH-1:0]          addr;
    logic [PEAK_NUM-1:0]            cand_valid;
    logic [PEAK_NUM*DIST_WIDTH-1:0] cand_dist;
    logic                           is_bloom;
    logic [REF_MAX*DIST_WIDTH-1:0]  ref_dist;
    logic [REF_CNT_W-1:0]           ref_count;
    logic                           contains_ref;
    logic                           ref_overflow;
    logic [CNT_WIDTH-1:0]           bloom_cnt;
    logic                           contains_bloom;

    // Requester / core side: drives commands and per-point data.
    modport master (
        output start, mode, abort, cand_valid, cand_dist, is_bloom,
        input  busy, done, rd_en, addr, ref_dist, ref_count, contains_ref,
               ref_overflow, bloom_cnt, contains_bloom
    );

    // Scan engine side.
    modport slave (
        input  start, mode, abort, cand_valid, cand_dist, is_bloom,
        output busy, done, rd_en, addr, ref_dist, ref_count, contains_ref,
               ref_overflow, bloom_cnt, contains_bloom
    );
endinterface

// File: rtl/blk_scan_engine.sv
// Block-scan controller: walks BLOCK_SIZE addresses per accepted start and
// gathers either a deduplicated reference-distance table or a bloom count.
//
// state | meaning
// IDLE  | waiting for start with a legal mode; results held
// SCAN  | issuing reads, addr 0..BLOCK_SIZE-1
// DRAIN | consuming the sample of the last address, then pulse done
module blk_scan_engine #(
    parameter int BLOCK_SIZE = 30,
    parameter int ADDR_WIDTH = 5,
    parameter int DIST_WIDTH = 14,
    parameter int PEAK_NUM   = 4,
    parameter int REF_MAX    = 3,
    parameter int REF_CNT_W  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    blk_scan_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [1:0]            MODE_REF   = 2'b01;
    localparam logic [1:0]            MODE_BLOOM = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(BLOCK_SIZE - 1);
    localparam logic [REF_CNT_W-1:0]  CNT_FULL   = REF_CNT_W'(REF_MAX);

    state_t                   state_q;
    logic [1:0]               mode_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     rd_en_q;
    logic                     sample_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DIST_WIDTH-1:0]    tbl_q [REF_MAX];
    logic [DIST_WIDTH-1:0]    tbl_d [REF_MAX];
    logic [REF_CNT_W-1:0]     ref_cnt_q;
    logic [REF_CNT_W-1:0]     ref_cnt_d;
    logic                     ovf_q;
    logic                     ovf_d;
    logic                     contains_ref_q;
    logic [CNT_WIDTH-1:0]     bloom_q;
    logic                     contains_bloom_q;

    logic                     mode_ok;
    logic                     abort_now;
    logic                     accept;
    logic [DIST_WIDTH-1:0]    cand;
    logic                     hit;
    logic [REF_MAX*DIST_WIDTH-1:0] ref_flat;

    assign mode_ok   = (bus.mode == MODE_REF) || (bus.mode == MODE_BLOOM);
    // Abort only means something while a scan is in flight; it beats start.
    assign abort_now = bus.abort && (state_q != IDLE);
    assign accept    = (state_q == IDLE) && bus.start && mode_ok;

    // Insert this point's candidates in peak order; later peaks see earlier inserts.
    always_comb begin
        tbl_d     = tbl_q;
        ref_cnt_d = ref_cnt_q;
        ovf_d     = ovf_q;
        cand      = '0;
        hit       = 1'b0;
        for (int p = 0; p < PEAK_NUM; p++) begin
            cand = bus.cand_dist[p*DIST_WIDTH +: DIST_WIDTH];
            hit  = 1'b0;
            if (bus.cand_valid[p] && (cand != '0)) begin
                for (int i = 0; i < REF_MAX; i++) begin
                    if ((REF_CNT_W'(i) < ref_cnt_d) && (tbl_d[i] == cand)) begin
                        hit = 1'b1;
                    end
                end
                if (!hit) begin
                    if (ref_cnt_d == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < REF_MAX; i++) begin
                            if (REF_CNT_W'(i) == ref_cnt_d) begin
                                tbl_d[i] = cand;
                            end
                        end
                        ref_cnt_d = ref_cnt_d + REF_CNT_W'(1);
                    end
                end
            end
        end
    end

    // Scan sequencing plus result accumulation; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mode_q           <= 2'b00;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            rd_en_q          <= 1'b0;
            sample_q         <= 1'b0;
            addr_q           <= '0;
            ref_cnt_q        <= '0;
            ovf_q            <= 1'b0;
            contains_ref_q   <= 1'b0;
            bloom_q          <= '0;
            contains_bloom_q <= 1'b0;
            for (int i = 0; i < REF_MAX; i++) tbl_q[i] <= '0;
        end else begin
            done_q   <= 1'b0;
            // The sample lags the read by one cycle; an abort drops it.
            sample_q <= rd_en_q && !abort_now;

            if (abort_now) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                addr_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q <= SCAN;
                            mode_q  <= bus.mode;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                            addr_q  <= '0;
                        end
                    end
                    SCAN: begin
                        if (addr_q == ADDR_LAST) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                            addr_q  <= '0;
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                    DRAIN: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (abort_now || accept) begin
                ref_cnt_q        <= '0;
                ovf_q            <= 1'b0;
                contains_ref_q   <= 1'b0;
                bloom_q          <= '0;
                contains_bloom_q <= 1'b0;
                for (int i = 0; i < REF_MAX; i++) tbl_q[i] <= '0;
            end else if (sample_q) begin
                if (mode_q == MODE_REF) begin
                    tbl_q          <= tbl_d;
                    ref_cnt_q      <= ref_cnt_d;
                    ovf_q          <= ovf_d;
                    contains_ref_q <= (ref_cnt_d != '0);
                end else if ((mode_q == MODE_BLOOM) && bus.is_bloom && (bloom_q != '1)) begin
                    bloom_q          <= bloom_q + CNT_WIDTH'(1);
                    contains_bloom_q <= 1'b1;
                end
            end
        end
    end

    // Flatten the table into the packed output bus.
    always_comb begin
        ref_flat = '0;
        for (int i = 0; i < REF_MAX; i++) begin
            ref_flat[i*DIST_WIDTH +: DIST_WIDTH] = tbl_q[i];
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.rd_en          = rd_en_q;
    assign bus.addr           = addr_q;
    assign bus.ref_dist       = ref_flat;
    assign bus.ref_count      = ref_cnt_q;
    assign bus.contains_ref   = contains_ref_q;
    assign bus.ref_overflow   = ovf_q;
    assign bus.bloom_cnt      = bloom_q;
    assign bus.contains_bloom = contains_bloom_q;
endmodule

// File: tb/tb_blk_scan_engine.sv
// Self-checking bench for blk_scan_engine: directed scenarios with literal
// expectations, then randomized traffic against a cycle-position model.
module tb_blk_scan_engine;
    localparam int BS  = 30;
    localparam int AW  = 5;
    localparam int DW  = 14;
    localparam int PN  = 4;
    localparam int RM  = 3;
    localparam int RCW = 2;
    localparam int CW  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blk_scan_engine_if #(.ADDR_WIDTH(AW), .DIST_WIDTH(DW), .PEAK_NUM(PN),
                         .REF_MAX(RM), .REF_CNT_W(RCW), .CNT_WIDTH(CW)) bus ();

    blk_scan_engine #(.BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .DIST_WIDTH(DW), .PEAK_NUM(PN),
                      .REF_MAX(RM), .REF_CNT_W(RCW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the core, per address.
    logic [PN-1:0] tv    [BS];
    logic [DW-1:0] td    [BS][PN];
    logic          tbl_b [BS];

    logic mem_hit = 1'b0;
    int   mem_a   = 0;

    always @(negedge clk) begin
        mem_hit = bus.rd_en;
        mem_a   = int'(bus.addr);
    end

    // Core answers the previous cycle's read; otherwise presents noise.
    always @(posedge clk) begin
        #2;
        if (mem_hit === 1'b1 && mem_a < BS) begin
            bus.cand_valid = tv[mem_a];
            for (int p = 0; p < PN; p++) bus.cand_dist[p*DW +: DW] = td[mem_a][p];
            bus.is_bloom = tbl_b[mem_a];
        end else begin
            bus.cand_valid = PN'($urandom);
            bus.cand_dist  = (PN*DW)'({$urandom, $urandom});
            bus.is_bloom   = 1'($urandom);
        end
    end

    // Reference model: phase = cycles since start accept (0 = idle).
    int          phase   = 0;
    logic [1:0]  m_mode  = 2'b00;
    int unsigned rtab[$];
    bit          m_ovf   = 0;
    int          m_bloom = 0;
    bit          e_done  = 0;
    int unsigned d;
    bit          seen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0; rtab.delete(); m_ovf = 0; m_bloom = 0; e_done = 0;
        end else begin
            e_done = 0;
            if (phase == 0) begin
                if (bus.start && (bus.mode == 2'b01 || bus.mode == 2'b10)) begin
                    phase = 1; m_mode = bus.mode;
                    rtab.delete(); m_ovf = 0; m_bloom = 0;
                end
            end else if (bus.abort) begin
                phase = 0; rtab.delete(); m_ovf = 0; m_bloom = 0;
            end else begin
                if (phase >= 2) begin
                    if (m_mode == 2'b01) begin
                        for (int p = 0; p < PN; p++) begin
                            d = bus.cand_dist[p*DW +: DW];
                            if (bus.cand_valid[p] && d != 0) begin
                                seen = 0;
                                foreach (rtab[i]) if (rtab[i] == d) seen = 1;
                                if (!seen) begin
                                    if (rtab.size() < RM) rtab.push_back(d);
                                    else m_ovf = 1;
                                end
                            end
                        end
                    end else if (bus.is_bloom && m_bloom < (2**CW) - 1) begin
                        m_bloom++;
                    end
                end
                if (phase == BS + 1) begin
                    phase = 0; e_done = 1;
                end else begin
                    phase++;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  bus.busy,  phase != 0);
            check("done",  bus.done,  e_done);
            check("rd_en", bus.rd_en, (phase >= 1 && phase <= BS));
            check("addr",  bus.addr,  (phase >= 1 && phase <= BS) ? phase - 1 : 0);
            check("ref_count",    bus.ref_count,    rtab.size());
            check("contains_ref", bus.contains_ref, rtab.size() != 0);
            check("ref_overflow", bus.ref_overflow, m_ovf);
            check("bloom_cnt",    bus.bloom_cnt,    m_bloom);
            check("contains_bloom", bus.contains_bloom, m_bloom != 0);
            for (int i = 0; i < RM; i++)
                check("ref_dist", bus.ref_dist[i*DW +: DW], (i < rtab.size()) ? rtab[i] : 0);
        end
    end

    task automatic clear_tab();
        for (int a = 0; a < BS; a++) begin
            tv[a] = '0; tbl_b[a] = 1'b0;
            for (int p = 0; p < PN; p++) td[a][p] = '0;
        end
    endtask

    // Called at posedge+2; returns at posedge+2 just after the sampling edge.
    task automatic pulse_start(input logic [1:0] m);
        bus.start = 1'b1; bus.mode = m;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    // Counts cycles after the start edge until done; ends at that cycle's negedge.
    task automatic wait_done(input string name, input int exp_lat);
        int  k = 0;
        bit  got = 0;
        while (k < 100 && !got) begin
            @(negedge clk);
            k++;
            if (bus.done === 1'b1) got = 1;
        end
        check(name, got ? k : -1, exp_lat);
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        logic [RM*DW-1:0] v;
        v = bus.ref_dist;
        return v[i*DW +: DW];
    endfunction

    int ndone;

    initial begin
        bus.start = 1'b0; bus.mode = 2'b00; bus.abort = 1'b0;
        bus.cand_valid = '0; bus.cand_dist = '0; bus.is_bloom = 1'b0;
        clear_tab();
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_ref_count", bus.ref_count, 0);
        check("rst_bloom", bus.bloom_cnt, 0);

        // Reference scan with a duplicate across points.
        tv[3] = 4'b0001; td[3][0] = 100;
        tv[7] = 4'b0011; td[7][0] = 100; td[7][1] = 200;
        pulse_start(2'b01);
        wait_done("ref_latency", BS + 2);
        check("ref_slot0", slot(0), 100);
        check("ref_slot1", slot(1), 200);
        check("ref_slot2", slot(2), 0);
        check("ref_cnt", bus.ref_count, 2);
        check("ref_contains", bus.contains_ref, 1);
        check("ref_ovf", bus.ref_overflow, 0);
        @(posedge clk); #2;

        // Overflow: four distinct peaks in one point.
        clear_tab();
        tv[0] = 4'hF; td[0][0] = 10; td[0][1] = 20; td[0][2] = 30; td[0][3] = 40;
        pulse_start(2'b01);
        wait_done("ovf_latency", BS + 2);
        check("ovf_slot0", slot(0), 10);
        check("ovf_slot1", slot(1), 20);
        check("ovf_slot2", slot(2), 30);
        check("ovf_cnt", bus.ref_count, 3);
        check("ovf_flag", bus.ref_overflow, 1);
        @(posedge clk); #2;

        // Zero, same-cycle duplicate and invalid peak.
        clear_tab();
        tv[0] = 4'b0111; td[0][0] = 0; td[0][1] = 50; td[0][2] = 50; td[0][3] = 60;
        pulse_start(2'b01);
        wait_done("dup_latency", BS + 2);
        check("dup_cnt", bus.ref_count, 1);
        check("dup_slot0", slot(0), 50);
        check("dup_ovf", bus.ref_overflow, 0);
        @(posedge clk); #2;

        // Bloom count, last address included.
        clear_tab();
        tbl_b[1] = 1; tbl_b[4] = 1; tbl_b[9] = 1; tbl_b[20] = 1; tbl_b[29] = 1;
        pulse_start(2'b10);
        wait_done("bloom_latency", BS + 2);
        check("bloom5", bus.bloom_cnt, 5);
        check("bloom5_contains", bus.contains_bloom, 1);
        check("bloom5_refcnt", bus.ref_count, 0);
        @(posedge clk); #2;

        // Saturation at 2^CW-1, then back-to-back start in the done cycle.
        clear_tab();
        for (int a = 0; a < 10; a++) tbl_b[a] = 1;
        pulse_start(2'b10);
        wait_done("sat_latency", BS + 2);
        check("bloom_sat", bus.bloom_cnt, 7);
        bus.start = 1'b1; bus.mode = 2'b01;
        @(posedge clk); #2;
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1);
        check("b2b_cleared", bus.bloom_cnt, 0);
        wait_done("b2b_latency", BS + 2);
        @(posedge clk); #2;

        // Abort at addr 12.
        clear_tab();
        tv[2] = 4'b0001; td[2][0] = 77;
        pulse_start(2'b01);
        repeat (12) @(posedge clk);
        #2;
        check("abort_addr", bus.addr, 12);
        bus.abort = 1'b1;
        @(posedge clk); #2;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_cleared", bus.ref_count, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_nodone", ndone, 0);
        @(posedge clk); #2;

        // Illegal mode, then start while busy.
        pulse_start(2'b11);
        check("illegal_mode_busy", bus.busy, 0);
        pulse_start(2'b10);
        repeat (4) @(posedge clk);
        #2;
        pulse_start(2'b01);
        wait_done("busy_start_latency", BS + 2 - 5);
        @(posedge clk); #2;

        // Reset at addr 20, then a clean scan.
        pulse_start(2'b01);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_rd_en", bus.rd_en, 0);
        check("rst_mid_addr", bus.addr, 0);
        check("rst_mid_refcnt", bus.ref_count, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        pulse_start(2'b10);
        wait_done("post_rst_latency", BS + 2);
        @(posedge clk); #2;

        // Randomized traffic; small distance range forces duplicates and overflow.
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                for (int a = 0; a < BS; a++) begin
                    tv[a] = PN'($urandom);
                    tbl_b[a] = ($urandom % 3 == 0);
                    for (int p = 0; p < PN; p++) td[a][p] = DW'($urandom_range(0, 6));
                end
            end
            bus.start = ($urandom % 5 == 0);
            bus.mode  = 2'($urandom);
            bus.abort = ($urandom % 90 == 0);
            @(posedge clk); #2;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (40) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
